// File: rtl/chrono_lcd_writer.sv
// chrono_lcd_writer: HD44780 4-bit mode writer for the chronometer time word.
// Optional: define CHRONO_LCD_BLANK_ZERO_EN to blank a zero tens-of-seconds digit.
module chrono_lcd_writer #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int ENABLE_CYCLES     = 12,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int CMD_CYCLES        = 2000,
  parameter int CLEAR_CYCLES      = 82000,
  parameter int INIT_CYCLES       = 205000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        lap_flag,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic [3:0]  lcd_data,
  output logic        ready,
  output logic        frame_done
);

  function automatic int maxi(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = maxi(maxi(maxi(POWERUP_CYCLES, ENABLE_CYCLES),
                                  maxi(NIBBLE_GAP_CYCLES, CMD_CYCLES)),
                             maxi(CLEAR_CYCLES, INIT_CYCLES));
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    PWRUP, INIT_NIB, INIT_CMD, FRAME_START, SEND_BYTE, FRAME_END
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP, PH_EN, PH_GAP, PH_WAIT
  } phase_e;

  state_e        state_q;
  phase_e        ph_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q;
  logic          hi_q;
  logic [15:0]   snap_dig_q;
  logic          snap_lap_q;

  logic [7:0]    cur_byte;
  logic [7:0]    nxt_byte;
  logic [CW-1:0] wait_len;

  function automatic logic [7:0] ascii_digit(logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  function automatic logic [7:0] init_cmd(logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(logic [3:0] i, logic [15:0] dg,
                                            logic lap);
    case (i)
      4'd0:    return 8'h80;
`ifdef CHRONO_LCD_BLANK_ZERO_EN
      4'd1:    return (dg[15:12] == 4'd0) ? 8'h20 : ascii_digit(dg[15:12]);
`else
      4'd1:    return ascii_digit(dg[15:12]);
`endif
      4'd2:    return ascii_digit(dg[11:8]);
      4'd3:    return 8'h2E;
      4'd4:    return ascii_digit(dg[7:4]);
      4'd5:    return ascii_digit(dg[3:0]);
      4'd7:    return lap ? 8'h4C : 8'h20;
      4'd8:    return lap ? 8'h41 : 8'h20;
      4'd9:    return lap ? 8'h50 : 8'h20;
      default: return 8'h20;
    endcase
  endfunction

  function automatic logic [3:0] pick(logic [7:0] b, logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

  always_comb begin
    if (state_q == INIT_CMD) begin
      cur_byte = init_cmd(idx_q[1:0]);
      nxt_byte = init_cmd(idx_q[1:0] + 2'd1);
    end else begin
      cur_byte = frame_byte(idx_q, snap_dig_q, snap_lap_q);
      nxt_byte = frame_byte(idx_q + 4'd1, snap_dig_q, snap_lap_q);
    end
  end

  // Last frame byte waits one cycle less; FRAME_END supplies the final cycle.
  always_comb begin
    wait_len = CW'(CMD_CYCLES - 1);
    if (state_q == INIT_NIB && idx_q == 4'd0)
      wait_len = CW'(INIT_CYCLES - 1);
    if (state_q == INIT_CMD && idx_q == 4'd3)
      wait_len = CW'(CLEAR_CYCLES - 1);
    if (state_q == SEND_BYTE && idx_q == 4'd9)
      wait_len = CW'(CMD_CYCLES - 2);
  end

  always_ff @(posedge clk_in) begin
    frame_done <= 1'b0;
    if (reset) begin
      state_q    <= PWRUP;
      ph_q       <= PH_SETUP;
      cnt_q      <= CW'(POWERUP_CYCLES - 1);
      idx_q      <= '0;
      hi_q       <= 1'b0;
      snap_dig_q <= '0;
      snap_lap_q <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_data   <= '0;
      ready      <= 1'b0;
    end else begin
      case (state_q)
        PWRUP: begin
          if (cnt_q == '0) begin
            state_q  <= INIT_NIB;
            ph_q     <= PH_SETUP;
            idx_q    <= '0;
            hi_q     <= 1'b0;
            lcd_data <= 4'h3;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        // Doubles as the setup cycle of the 0x80 high nibble.
        FRAME_START: begin
          snap_dig_q <= digits;
          snap_lap_q <= lap_flag;
          state_q    <= SEND_BYTE;
          idx_q      <= '0;
          hi_q       <= 1'b1;
          ph_q       <= PH_EN;
          lcd_e      <= 1'b1;
          cnt_q      <= CW'(ENABLE_CYCLES - 1);
        end
        FRAME_END: begin
          state_q  <= FRAME_START;
          lcd_rs   <= 1'b0;
          lcd_data <= 4'h8;
        end
        default: begin
          case (ph_q)
            PH_SETUP: begin
              lcd_e <= 1'b1;
              ph_q  <= PH_EN;
              cnt_q <= CW'(ENABLE_CYCLES - 1);
            end
            PH_EN: begin
              if (cnt_q == '0) begin
                lcd_e <= 1'b0;
                ph_q  <= PH_GAP;
                cnt_q <= CW'(NIBBLE_GAP_CYCLES - 1);
              end else begin
                cnt_q <= cnt_q - CW'(1);
              end
            end
            PH_GAP: begin
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
              end else if (hi_q) begin
                hi_q     <= 1'b0;
                lcd_data <= pick(cur_byte, 1'b0);
                ph_q     <= PH_SETUP;
              end else begin
                ph_q  <= PH_WAIT;
                cnt_q <= wait_len;
              end
            end
            default: begin
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
              end else begin
                ph_q  <= PH_SETUP;
                idx_q <= idx_q + 4'd1;
                case (state_q)
                  INIT_NIB: begin
                    if (idx_q == 4'd3) begin
                      state_q  <= INIT_CMD;
                      idx_q    <= '0;
                      hi_q     <= 1'b1;
                      lcd_data <= 4'h2;
                    end else begin
                      lcd_data <= (idx_q == 4'd2) ? 4'h2 : 4'h3;
                    end
                  end
                  INIT_CMD: begin
                    if (idx_q == 4'd3) begin
                      state_q  <= FRAME_START;
                      ready    <= 1'b1;
                      lcd_data <= 4'h8;
                    end else begin
                      hi_q     <= 1'b1;
                      lcd_data <= pick(nxt_byte, 1'b1);
                    end
                  end
                  default: begin
                    if (idx_q == 4'd9) begin
                      state_q    <= FRAME_END;
                      frame_done <= 1'b1;
                    end else begin
                      hi_q     <= 1'b1;
                      lcd_rs   <= 1'b1;
                      lcd_data <= pick(nxt_byte, 1'b1);
                    end
                  end
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chrono_lcd_writer.sv
// tb_chrono_lcd_writer: directed bench for the chronometer LCD writer.
// Captures strobed nibbles and compares init and frame contents.
module tb_chrono_lcd_writer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0;
  logic        lap_flag = 1'b0;
  logic        lcd_rs;
  logic        lcd_e;
  logic [3:0]  lcd_data;
  logic        ready;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  chrono_lcd_writer #(
    .POWERUP_CYCLES(20),
    .ENABLE_CYCLES(2),
    .NIBBLE_GAP_CYCLES(3),
    .CMD_CYCLES(10),
    .CLEAR_CYCLES(30),
    .INIT_CYCLES(40)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .digits(digits),
    .lap_flag(lap_flag),
    .lcd_rs(lcd_rs),
    .lcd_e(lcd_e),
    .lcd_data(lcd_data),
    .ready(ready),
    .frame_done(frame_done)
  );

  logic [4:0] nq[$];
  logic       e_prev = 1'b0;
  logic [4:0] hold = 5'h0;
  int         unstable = 0;
  int         fd_cnt = 0;

  always @(negedge clk_in) begin
    if (lcd_e && !e_prev) nq.push_back({lcd_rs, lcd_data});
    else if (lcd_e && ({lcd_rs, lcd_data} !== hold)) unstable++;
    if (frame_done) fd_cnt++;
    e_prev = lcd_e;
    hold = {lcd_rs, lcd_data};
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  function automatic logic [71:0] str9(string s);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[71-8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic grab(input int chg_at, input logic [15:0] chg_val,
                      output logic [79:0] b, output logic [9:0] r,
                      output bit ok);
    int n;
    n = 0;
    b = '0;
    r = '0;
    while (frame_done !== 1'b1 && n < 3000) begin tick(); n++; end
    nq.delete();
    fd_cnt = 0;
    while (nq.size() < 20 && n < 3000) begin
      tick();
      n++;
      if (chg_at > 0 && nq.size() >= chg_at) digits = chg_val;
    end
    while (frame_done !== 1'b1 && n < 3000) begin tick(); n++; end
    ok = (n < 3000) && (nq.size() >= 20);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        b[79-8*i -: 8] = {nq[2*i][3:0], nq[2*i+1][3:0]};
        r[9-i] = nq[2*i][4];
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL reset_e got=%b want=0", lcd_e); end
    total++; if (lcd_rs !== 1'b0) begin bad++; $display("FAIL reset_rs got=%b want=0", lcd_rs); end
    total++; if (lcd_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h want=0", lcd_data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    nq.delete();
    reset = 1'b0;
  endtask

  task automatic test_init();
    int quiet;
    int n;
    logic [59:0] got;
    logic [59:0] want;
    quiet = 0;
    n = 0;
    got = '0;
    want = {5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
            5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    for (int i = 0; i < 20; i++) begin
      tick();
      if (lcd_e !== 1'b0) quiet++;
    end
    total++; if (quiet != 0) begin bad++; $display("FAIL pwrup_quiet got=%0d want=0", quiet); end
    while (nq.size() < 12 && n < 3000) begin tick(); n++; end
    total++;
    if (nq.size() < 12) begin
      bad++;
      $display("FAIL init_seq got=%0d nibbles want=12", nq.size());
    end else begin
      for (int i = 0; i < 12; i++) got[59-5*i -: 5] = nq[i];
      if (got !== want) begin bad++; $display("FAIL init_seq got=%h want=%h", got, want); end
    end
    repeat (34) tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%b want=0", ready); end
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%b want=1", ready); end
  endtask

  task automatic test_frame_1234();
    logic [79:0] b;
    logic [9:0] r;
    bit ok;
    digits = 16'h1234;
    lap_flag = 1'b0;
    grab(0, 16'h0, b, r, ok);
    total++; if (!ok || b !== {8'h80, str9("12.34    ")}) begin bad++; $display("FAIL f1234_bytes got=%h ok=%0d", b, ok); end
    total++; if (!ok || r !== 10'b0111111111) begin bad++; $display("FAIL f1234_rs got=%b want=0111111111", r); end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL f1234_fd_count got=%0d want=1", fd_cnt); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL f1234_fd_width got=%b want=0", frame_done); end
  endtask

  task automatic test_lap();
    logic [79:0] b;
    logic [9:0] r;
    bit ok;
    logic [71:0] want;
`ifdef CHRONO_LCD_BLANK_ZERO_EN
    want = str9(" 5.07 LAP");
`else
    want = str9("05.07 LAP");
`endif
    digits = 16'h0507;
    lap_flag = 1'b1;
    grab(0, 16'h0, b, r, ok);
    total++; if (!ok || b !== {8'h80, want}) begin bad++; $display("FAIL lap_bytes got=%h want=%h", b, {8'h80, want}); end
    total++; if (!ok || r !== 10'b0111111111) begin bad++; $display("FAIL lap_rs got=%b want=0111111111", r); end
    lap_flag = 1'b0;
  endtask

  task automatic test_snapshot();
    logic [79:0] b;
    logic [9:0] r;
    bit ok;
    digits = 16'h1111;
    grab(0, 16'h0, b, r, ok);
    grab(8, 16'h2222, b, r, ok);
    total++; if (!ok || b !== {8'h80, str9("11.11    ")}) begin bad++; $display("FAIL snap_old got=%h ok=%0d", b, ok); end
    grab(0, 16'h0, b, r, ok);
    total++; if (!ok || b !== {8'h80, str9("22.22    ")}) begin bad++; $display("FAIL snap_new got=%h ok=%0d", b, ok); end
  endtask

  task automatic test_bad_bcd();
    logic [79:0] b;
    logic [9:0] r;
    bit ok;
    digits = 16'hA9F0;
    grab(0, 16'h0, b, r, ok);
    total++; if (!ok || b !== {8'h80, str9("?9.?0    ")}) begin bad++; $display("FAIL bad_bcd got=%h ok=%0d", b, ok); end
  endtask

  task automatic test_reset_midframe();
    int n;
    n = 0;
    while (lcd_e !== 1'b1 && n < 1000) begin tick(); n++; end
    reset = 1'b1;
    tick();
    total++; if (n >= 1000 || lcd_e !== 1'b0) begin bad++; $display("FAIL midreset_e got=%b want=0", lcd_e); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b want=0", ready); end
    tick();
    tick();
    nq.delete();
    reset = 1'b0;
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame_1234();
    test_lap();
    test_snapshot();
    test_bad_bcd();
    test_reset_midframe();
    test_frame_1234();
    total++; if (unstable != 0) begin bad++; $display("FAIL strobe_stable got=%0d changes want=0", unstable); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
